aq_idu_id_gpr_wb_ctrl: RTL

- Writeback decode and pending-write tracking stage directly upstream of the per-register GPR gated registers in IDU.
- Accepts the two RTU writeback ports (index + data) and registers them for one cycle.
- Decodes them into the per-register one-hot valid vectors (wb0_vld_x / wb1_vld_x) and the shared data buses that each GPR entry consumes.
- Keeps a per-register pending-write counter, incremented at ID dispatch and decremented at writeback; it drives operand-busy and dispatch-stall signals.

---
 rtl/idu_gpr_pkg.sv | 22 ++
 rtl/aq_idu_id_gpr_pend_cnt.sv | 46 ++++
 rtl/aq_idu_id_gpr_wb_ctrl.sv | 86 ++++++++
 3 files changed

// File: rtl/idu_gpr_pkg.sv
// Shared GPR writeback constants and helpers.
// Used by the IDU writeback decode and pending-count logic.
package idu_gpr_pkg;

  localparam int NUM_GPR = 32;
  localparam int IDX_W   = 5;
  localparam int DATA_W  = 64;
  localparam int CNT_W   = 2;

  localparam logic [IDX_W-1:0] GPR_X0  = '0;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [NUM_GPR-1:0] gpr_onehot(
    input logic [IDX_W-1:0] idx
  );
    logic [NUM_GPR-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/aq_idu_id_gpr_pend_cnt.sv
// Pending-write counter for one GPR.
// Up on dispatch, down by 0..2 writebacks, flush clears.
module aq_idu_id_gpr_pend_cnt
  import idu_gpr_pkg::*;
(
  input  logic             forever_cpuclk,
  input  logic             cpurst,
  input  logic             flush,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W:0]   up;
  logic [CNT_W:0]   dn;
  logic [CNT_W:0]   diff;
  logic [CNT_W-1:0] cnt_nxt;

  // Net update, clamped to 0 on underflow and to CNT_MAX on overflow
  always_comb begin
    up      = {1'b0, cnt} + (CNT_W+1)'(inc);
    dn      = (CNT_W+1)'(dec);
    diff    = up - dn;
    cnt_nxt = diff[CNT_W-1:0];
    if (dn > up)
      cnt_nxt = '0;
    else if (diff > {1'b0, CNT_MAX})
      cnt_nxt = CNT_MAX;
  end

  // Counter register; flush wins over inc/dec
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst)
      cnt <= '0;
    else if (flush)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

  a_no_underflow: assert property (
    @(posedge forever_cpuclk) disable iff (cpurst || flush)
    dn <= up
  );

endmodule

// File: rtl/aq_idu_id_gpr_wb_ctrl.sv
// IDU GPR writeback decode and pending-write tracking.
// One-cycle writeback register stage plus per-register busy/stall.
module aq_idu_id_gpr_wb_ctrl
  import idu_gpr_pkg::*;
(
  input  logic               forever_cpuclk,
  input  logic               cpurst,
  input  logic               rtu_idu_wb0_vld,
  input  logic [IDX_W-1:0]   rtu_idu_wb0_preg,
  input  logic [DATA_W-1:0]  rtu_idu_wb0_data,
  input  logic               rtu_idu_wb1_vld,
  input  logic [IDX_W-1:0]   rtu_idu_wb1_preg,
  input  logic [DATA_W-1:0]  rtu_idu_wb1_data,
  input  logic               id_dispatch_vld,
  input  logic [IDX_W-1:0]   id_dispatch_preg,
  input  logic               rtu_yy_xx_flush,
  output logic [NUM_GPR-1:0] wb0_vld_x,
  output logic [NUM_GPR-1:0] wb1_vld_x,
  output logic [DATA_W-1:0]  idu_gpr_wb0_data,
  output logic [DATA_W-1:0]  idu_gpr_wb1_data,
  output logic [NUM_GPR-1:0] gpr_busy,
  output logic               idu_id_dispatch_stall
);

  logic [NUM_GPR-1:0] wb0_hit;
  logic [NUM_GPR-1:0] wb1_hit;
  logic [NUM_GPR-1:0] wb0_en;
  logic [NUM_GPR-1:0] wb1_en;
  logic               disp_wb_hit;
  logic [CNT_W-1:0]   cnt [NUM_GPR];

  // Decode ports; x0 dropped, younger port wins a collision
  always_comb begin
    wb0_hit = rtu_idu_wb0_vld ? gpr_onehot(rtu_idu_wb0_preg) : '0;
    wb1_hit = rtu_idu_wb1_vld ? gpr_onehot(rtu_idu_wb1_preg) : '0;
    wb1_en  = wb1_hit & ~gpr_onehot(GPR_X0);
    wb0_en  = wb0_hit & ~wb1_hit & ~gpr_onehot(GPR_X0);
  end

  // Stall when target is saturated and no writeback frees it now
  always_comb begin
    disp_wb_hit =
      (rtu_idu_wb0_vld && rtu_idu_wb0_preg == id_dispatch_preg) ||
      (rtu_idu_wb1_vld && rtu_idu_wb1_preg == id_dispatch_preg);
    idu_id_dispatch_stall = id_dispatch_vld &&
      cnt[id_dispatch_preg] == CNT_MAX && !disp_wb_hit;
  end

  // Writeback register stage; flush does not cancel retired results
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      wb0_vld_x        <= '0;
      wb1_vld_x        <= '0;
      idu_gpr_wb0_data <= '0;
      idu_gpr_wb1_data <= '0;
    end else begin
      wb0_vld_x        <= wb0_en;
      wb1_vld_x        <= wb1_en;
      idu_gpr_wb0_data <= rtu_idu_wb0_vld ? rtu_idu_wb0_data : '0;
      idu_gpr_wb1_data <= rtu_idu_wb1_vld ? rtu_idu_wb1_data : '0;
    end
  end

  assign cnt[0] = '0;

  for (genvar i = 1; i < NUM_GPR; i++) begin : g_cnt
    logic       inc;
    logic [1:0] dec;
    assign inc = id_dispatch_vld && !idu_id_dispatch_stall &&
                 id_dispatch_preg == IDX_W'(i);
    assign dec = {wb0_hit[i] & wb1_hit[i], wb0_hit[i] ^ wb1_hit[i]};
    aq_idu_id_gpr_pend_cnt u_cnt (
      .forever_cpuclk (forever_cpuclk),
      .cpurst         (cpurst),
      .flush          (rtu_yy_xx_flush),
      .inc            (inc),
      .dec            (dec),
      .cnt            (cnt[i])
    );
  end

  for (genvar i = 0; i < NUM_GPR; i++) begin : g_busy
    assign gpr_busy[i] = cnt[i] != '0;
  end

endmodule
